selector_arb: RTL and testbench

Registered, handshaked successor to the combinational `selector`. It arbitrates among `IN` request channels of `DATA` bits each, using fixed priority (LSB- or MSB-first) or round-robin. The winning word and its one-hot position are captured into a single-entry output register with valid/ready flow control. It sits between multiple producers and one downstream consumer wherever the plain selector needs back-pressure and fairness.

---
 rtl/selector_arb.sv | 102 ++++++++++
 tb/tb_selector_arb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/selector_arb.sv
// Registered, handshaked multi-channel selector: fixed-priority or round-robin
// arbitration into a single-entry valid/ready output register.
module selector_arb #(
  parameter int DATA = 32,
  parameter int IN   = 4,
  parameter bit ACT  = 1'b1,
  parameter bit MSB  = 1'b1,
  parameter bit RR   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA*IN-1:0]   in,
  input  logic [IN-1:0]        req,
  output logic [IN-1:0]        grant,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [IN-1:0]        pos,
  output logic [DATA-1:0]      out
);

  localparam int IW = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(IN - 1);
  localparam logic [IN-1:0] ONE = {{(IN-1){1'b0}}, 1'b1};

  // Handshake: a word moves downstream on every rising edge where
  // out_valid=1 and out_ready=1; out/pos are stable while out_valid waits.
  // The FSM state (EMPTY/FULL) is out_valid itself.

  logic [IN-1:0] act;
  logic          any_req;
  logic          load;
  logic [IW-1:0] win;
  logic [IW-1:0] last;
  logic [IN-1:0] win_oh;
  logic          valid_next;
  logic          hit;
  int            j;

  assign act     = ACT ? req : ~req;
  assign any_req = |act;
  assign load    = (!out_valid || out_ready) && any_req && !reset;
  assign win_oh  = ONE << win;

  always_comb begin
    win = '0;
    hit = 1'b0;
    j   = 0;
    if (RR) begin
      // Ascending search starting just after the previous winner, wrapping.
      for (int k = 1; k <= IN; k++) begin
        j = (int'(last) + k) % IN;
        if (!hit && act[j]) begin
          hit = 1'b1;
          win = IW'(j);
        end
      end
    end else if (MSB) begin
      for (int i = 0; i < IN; i++) begin
        if (act[i]) win = IW'(i);
      end
    end else begin
      for (int i = IN - 1; i >= 0; i--) begin
        if (act[i]) win = IW'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_valid <= 1'b0;
    else       out_valid <= valid_next;
  end

  // Next-state logic
  always_comb begin
    valid_next = out_valid;
    if (load)                        valid_next = 1'b1;
    else if (out_valid && out_ready) valid_next = 1'b0;
  end

  // Output logic
  always_comb begin
    grant = ACT ? '0 : '1;
    if (load) grant = ACT ? win_oh : ~win_oh;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= '0;
      pos <= '0;
    end else if (load) begin
      out <= in[DATA*win +: DATA];
      pos <= win_oh;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            last <= LAST_RST;
    else if (RR && load)  last <= win;
  end

endmodule

// File: tb/tb_selector_arb.sv
// Bench for selector_arb: four parameter variants share one stimulus stream
// and are compared against a per-variant behavioural model.
module tb_selector_arb;

  logic          clk = 1'b0;
  logic          reset;
  logic [127:0]  in_bus;
  logic [3:0]    act_req;
  logic [3:0]    req_hi, req_lo;
  logic          out_ready;

  logic [3:0]    g_a[4];
  logic          v_a[4];
  logic [3:0]    p_a[4];
  logic [31:0]   o_a[4];

  int checks = 0;
  int failures = 0;

  // Model state; variant 0 = MSB fixed, 1 = LSB fixed, 2 = round-robin,
  // 3 = MSB fixed with active-low req/grant.
  logic          m_v[4];
  logic [3:0]    m_pos[4];
  logic [31:0]   m_out[4];
  int            m_last[4];
  logic [31:0]   exp_q[$];

  assign req_hi = act_req;
  assign req_lo = ~act_req;

  always #5 clk = ~clk;

  selector_arb #(.DATA(32), .IN(4), .ACT(1'b1), .MSB(1'b1), .RR(1'b0)) u_msb (
    .clk(clk), .reset(reset), .in(in_bus), .req(req_hi), .grant(g_a[0]),
    .out_ready(out_ready), .out_valid(v_a[0]), .pos(p_a[0]), .out(o_a[0]));
  selector_arb #(.DATA(32), .IN(4), .ACT(1'b1), .MSB(1'b0), .RR(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in(in_bus), .req(req_hi), .grant(g_a[1]),
    .out_ready(out_ready), .out_valid(v_a[1]), .pos(p_a[1]), .out(o_a[1]));
  selector_arb #(.DATA(32), .IN(4), .ACT(1'b1), .MSB(1'b1), .RR(1'b1)) u_rr (
    .clk(clk), .reset(reset), .in(in_bus), .req(req_hi), .grant(g_a[2]),
    .out_ready(out_ready), .out_valid(v_a[2]), .pos(p_a[2]), .out(o_a[2]));
  selector_arb #(.DATA(32), .IN(4), .ACT(1'b0), .MSB(1'b1), .RR(1'b0)) u_low (
    .clk(clk), .reset(reset), .in(in_bus), .req(req_lo), .grant(g_a[3]),
    .out_ready(out_ready), .out_valid(v_a[3]), .pos(p_a[3]), .out(o_a[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input int k, input logic [3:0] a);
    int w = 0;
    if (k == 2) begin
      for (int s = 4; s >= 1; s--)
        if (a[(m_last[k] + s) % 4]) w = (m_last[k] + s) % 4;
    end else if (k == 1) begin
      for (int i = 3; i >= 0; i--) if (a[i]) w = i;
    end else begin
      for (int i = 0; i < 4; i++) if (a[i]) w = i;
    end
    return w;
  endfunction

  function automatic logic model_load(input int k);
    return (!m_v[k] || out_ready) && (act_req != 4'b0000);
  endfunction

  function automatic logic [3:0] exp_grant(input int k);
    logic [3:0] oh = 4'b0000;
    if (model_load(k)) oh = 4'(1 << winner(k, act_req));
    return (k == 3) ? ~oh : oh;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_v[k] = 1'b0;
      m_pos[k] = 4'b0000;
      m_out[k] = 32'd0;
      m_last[k] = 3;
    end
  endtask

  task automatic model_step();
    int w;
    for (int k = 0; k < 4; k++) begin
      if (model_load(k)) begin
        w = winner(k, act_req);
        m_out[k] = in_bus[32*w +: 32];
        m_pos[k] = 4'(1 << w);
        m_v[k] = 1'b1;
        m_last[k] = w;
      end else if (m_v[k] && out_ready) begin
        m_v[k] = 1'b0;
      end
      exp_q.push_back(m_out[k]);
    end
  endtask

  task automatic cycle(input logic [3:0] a, input logic rdy);
    @(negedge clk);
    act_req = a;
    out_ready = rdy;
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("grant[%0d]", k), 32'(g_a[k]), 32'(exp_grant(k)));
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("valid[%0d]", k), 32'(v_a[k]), 32'(m_v[k]));
      check($sformatf("pos[%0d]", k), 32'(p_a[k]), 32'(m_pos[k]));
      check($sformatf("out[%0d]", k), o_a[k], exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_valid[%0d]", k), 32'(v_a[k]), 32'd0);
      check($sformatf("rst_pos[%0d]", k), 32'(p_a[k]), 32'd0);
      check($sformatf("rst_out[%0d]", k), o_a[k], 32'd0);
      check($sformatf("rst_grant[%0d]", k), 32'(g_a[k]), (k == 3) ? 32'hF : 32'h0);
    end
    @(posedge clk);
    @(negedge clk);
    act_req = 4'b0000;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    act_req = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) in_bus[32*i +: 32] = 32'(i + 1);
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Fill with channel 2, then reset between edges while FULL
    cycle(4'b0100, 1'b1);
    check("fill_out3", o_a[0], 32'd3);
    do_reset();
    cycle(4'b0100, 1'b1);
    check("post_rst_out", o_a[0], 32'd3);
    check("post_rst_pos", 32'(p_a[0]), 32'h4);

    // Fixed priority both directions
    cycle(4'b1011, 1'b1);
    check("msb_out", o_a[0], 32'd4);
    check("msb_pos", 32'(p_a[0]), 32'h8);
    check("lsb_out", o_a[1], 32'd1);

    // Back-pressure: held word and idle grant, then replace on release
    cycle(4'b0010, 1'b1);
    repeat (3) begin
      cycle(4'b1111, 1'b0);
      check("bp_hold_out", o_a[0], 32'd2);
      check("bp_hold_valid", 32'(v_a[0]), 32'd1);
    end
    cycle(4'b1111, 1'b1);
    check("bp_release_out", o_a[0], 32'd4);

    // Drain with no request
    cycle(4'b0000, 1'b1);
    check("drain_valid", 32'(v_a[0]), 32'd0);
    check("drain_out", o_a[0], 32'd4);
    check("drain_pos", 32'(p_a[0]), 32'h8);

    // Round-robin rotation from reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 1'b1);
      check($sformatf("rr_all_%0d", i), o_a[2], 32'((i % 4) + 1));
    end
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0101, 1'b1);
      check($sformatf("rr_alt_%0d", i), o_a[2], (i % 2 == 0) ? 32'd1 : 32'd3);
    end

    // Active-low variant with only channel 1 active
    cycle(4'b0010, 1'b1);
    check("low_out", o_a[3], 32'd2);
    check("low_pos", 32'(p_a[3]), 32'h2);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) in_bus[32*i +: 32] = $urandom;
      if ($urandom_range(0, 39) == 0) do_reset();
      cycle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
